ad_tx: RTL and testbench

AD_TX -- requirements
Module: ad_tx

---
 rtl/ad_tx.sv | 167 ++++++++++++++++
 tb/tb_ad_tx.sv | 367 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ad_tx.sv
// AD sample transmitter: buffers samples in a small FIFO and shifts one out MSB-first
// per frame of an externally clocked reader (cs_n/sclk), all in the clk_sys domain.
module ad_tx #(
  parameter int unsigned DW    = 16,
  parameter int unsigned DEPTH = 4
) (
  input  logic                   clk_sys,
  input  logic                   rst,
  input  logic                   cs_n,
  input  logic                   sclk,
  output logic                   sdata,
  input  logic                   smp_wr,
  input  logic [DW-1:0]          smp_data,
  output logic                   smp_full,
  output logic [$clog2(DEPTH):0] smp_level,
  input  logic                   ramp_en,
  input  logic                   stat_clr,
  output logic                   underrun,
  output logic                   short_frame,
  output logic [15:0]            frame_cnt
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;
  localparam int unsigned CW = $clog2(DW + 1);

  typedef enum logic [1:0] {WAIT_HI, ARMED, SHIFT, DONE} state_t;

  state_t        state;
  logic [2:0]    cs_sync;
  logic [2:0]    sclk_sync;
  logic [1:0]    sync_age;
  logic [DW-1:0] shreg;
  logic [CW-1:0] bit_cnt;
  logic [DW-1:0] ramp;
  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;

  logic          sync_ok_c;
  logic          cs_fall_c;
  logic          cs_rise_c;
  logic          sclk_fall_c;
  logic          start_c;
  logic          pop_c;
  logic          push_c;
  logic [LW-1:0] level_nxt_c;
  logic [DW-1:0] load_val_c;
  logic          underrun_set_c;
  logic          short_set_c;
  logic          frame_done_c;

  // Two-flop synchronisers plus a third copy for edge detection; the age counter
  // masks the forced-high reset values until the chain reflects the real pins.
  always_ff @(posedge clk_sys) begin
    if (rst) begin
      cs_sync   <= 3'b111;
      sclk_sync <= 3'b111;
      sync_age  <= 2'd0;
    end else begin
      cs_sync   <= {cs_sync[1:0], cs_n};
      sclk_sync <= {sclk_sync[1:0], sclk};
      if (sync_age != 2'd2) sync_age <= sync_age + 2'd1;
    end
  end

  always_comb begin
    sync_ok_c      = (sync_age == 2'd2);
    cs_fall_c      = cs_sync[2] & ~cs_sync[1];
    cs_rise_c      = ~cs_sync[2] & cs_sync[1];
    sclk_fall_c    = sclk_sync[2] & ~sclk_sync[1];
    start_c        = (state == ARMED) && cs_fall_c;
    pop_c          = start_c && (smp_level != '0);
    push_c         = smp_wr && (!smp_full || pop_c);
    level_nxt_c    = smp_level + LW'(push_c) - LW'(pop_c);
    load_val_c     = pop_c ? mem[rd_ptr] : (ramp_en ? ramp : '0);
    underrun_set_c = start_c && !pop_c;
    short_set_c    = (state == SHIFT) && cs_rise_c;
    frame_done_c   = (state == DONE) && cs_rise_c;
  end

  always_ff @(posedge clk_sys) begin
    if (push_c) mem[wr_ptr] <= smp_data;
  end

  // FIFO pointers and registered occupancy flags
  always_ff @(posedge clk_sys) begin
    if (rst) begin
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      smp_level <= '0;
      smp_full  <= 1'b0;
    end else begin
      if (pop_c)  rd_ptr <= rd_ptr + AW'(1);
      if (push_c) wr_ptr <= wr_ptr + AW'(1);
      smp_level <= level_nxt_c;
      smp_full  <= (level_nxt_c == LW'(DEPTH));
    end
  end

  // Frame FSM; sdata is registered alongside the shift register so a pin edge
  // shows on sdata on the third clk_sys edge after it.
  always_ff @(posedge clk_sys) begin
    if (rst) begin
      state   <= WAIT_HI;
      sdata   <= 1'b0;
      shreg   <= '0;
      bit_cnt <= '0;
      ramp    <= '0;
    end else begin
      case (state)
        WAIT_HI: begin
          sdata <= 1'b0;
          if (sync_ok_c && cs_sync[1]) state <= ARMED;
        end
        ARMED: begin
          sdata <= 1'b0;
          if (cs_fall_c) begin
            shreg   <= load_val_c;
            sdata   <= load_val_c[DW-1];
            bit_cnt <= '0;
            state   <= SHIFT;
            if (!pop_c && ramp_en) ramp <= ramp + DW'(1);
          end
        end
        SHIFT: begin
          if (cs_rise_c) begin
            sdata <= 1'b0;
            state <= ARMED;
          end else if (sclk_fall_c) begin
            shreg   <= {shreg[DW-2:0], 1'b0};
            bit_cnt <= bit_cnt + CW'(1);
            if (bit_cnt == CW'(DW - 1)) begin
              sdata <= 1'b0;
              state <= DONE;
            end else begin
              sdata <= shreg[DW-2];
            end
          end
        end
        DONE: begin
          sdata <= 1'b0;
          if (cs_rise_c) state <= ARMED;
        end
        default: begin
          sdata <= 1'b0;
          state <= WAIT_HI;
        end
      endcase
    end
  end

  // Sticky status; a set event in the same cycle as stat_clr wins.
  always_ff @(posedge clk_sys) begin
    if (rst) begin
      underrun    <= 1'b0;
      short_frame <= 1'b0;
      frame_cnt   <= '0;
    end else begin
      underrun    <= underrun_set_c | (underrun & ~stat_clr);
      short_frame <= short_set_c | (short_frame & ~stat_clr);
      if (frame_done_c)  frame_cnt <= stat_clr ? 16'd1 : frame_cnt + 16'd1;
      else if (stat_clr) frame_cnt <= '0;
    end
  end

endmodule

// File: tb/tb_ad_tx.sv
// Bench for ad_tx: emulates the AD reader on cs_n/sclk and checks captured samples
// and status against a queue-based model of the FIFO, ramp and counters.
module tb_ad_tx;

  localparam int DW    = 16;
  localparam int DEPTH = 4;
  localparam int LW    = 3;

  logic          clk_sys = 1'b0;
  logic          rst = 1'b1;
  logic          cs_n = 1'b1;
  logic          sclk = 1'b0;
  logic          sdata;
  logic          smp_wr = 1'b0;
  logic [DW-1:0] smp_data = '0;
  logic          smp_full;
  logic [LW-1:0] smp_level;
  logic          ramp_en = 1'b0;
  logic          stat_clr = 1'b0;
  logic          underrun;
  logic          short_frame;
  logic [15:0]   frame_cnt;

  int checks = 0;
  int failures = 0;

  // Reference model state
  logic [DW-1:0] mq[$];
  logic [DW-1:0] ramp_m = '0;
  logic          uf_m = 1'b0;
  logic          sf_m = 1'b0;
  logic [15:0]   fc_m = '0;

  ad_tx #(.DW(DW), .DEPTH(DEPTH)) dut (
    .clk_sys(clk_sys), .rst(rst), .cs_n(cs_n), .sclk(sclk), .sdata(sdata),
    .smp_wr(smp_wr), .smp_data(smp_data), .smp_full(smp_full), .smp_level(smp_level),
    .ramp_en(ramp_en), .stat_clr(stat_clr), .underrun(underrun),
    .short_frame(short_frame), .frame_cnt(frame_cnt)
  );

  always #5 clk_sys = ~clk_sys;

  task automatic cyc(input int n);
    repeat (n) @(posedge clk_sys);
    #1;
  endtask

  function automatic logic [DW-1:0] model_load();
    logic [DW-1:0] r;
    if (mq.size() > 0) begin
      r = mq.pop_front();
    end else begin
      uf_m = 1'b1;
      if (ramp_en) begin
        r = ramp_m;
        ramp_m = ramp_m + 1'b1;
      end else begin
        r = '0;
      end
    end
    return r;
  endfunction

  task automatic wr(input logic [DW-1:0] d);
    smp_wr = 1'b1;
    smp_data = d;
    cyc(1);
    smp_wr = 1'b0;
    if (mq.size() < DEPTH) mq.push_back(d);
  endtask

  task automatic clr_pulse();
    stat_clr = 1'b1;
    cyc(1);
    stat_clr = 1'b0;
    uf_m = 1'b0;
    sf_m = 1'b0;
    fc_m = '0;
  endtask

  // cs_n fall; the DUT acts on it at the third edge, where an optional write lands.
  task automatic frame_start(input bit wr_pop, input logic [DW-1:0] d, output logic [DW-1:0] exp);
    cs_n = 1'b0;
    cyc(2);
    if (wr_pop) begin
      smp_wr = 1'b1;
      smp_data = d;
    end
    cyc(1);
    smp_wr = 1'b0;
    exp = model_load();
    if (wr_pop && mq.size() < DEPTH) mq.push_back(d);
    cyc(1);
  endtask

  task automatic shift_bits(input int n, output logic [DW-1:0] cap);
    int ph;
    cap = '0;
    for (int i = 0; i < n; i++) begin
      ph = $urandom_range(4, 6);
      sclk = 1'b1;
      cap = {cap[DW-2:0], sdata};
      cyc(ph);
      sclk = 1'b0;
      cyc(ph);
    end
  endtask

  task automatic frame_end(input bit clr, input bit complete);
    cs_n = 1'b1;
    cyc(2);
    if (clr) stat_clr = 1'b1;
    cyc(1);
    stat_clr = 1'b0;
    if (clr) begin
      uf_m = 1'b0;
      sf_m = 1'b0;
      fc_m = '0;
    end
    if (complete) fc_m = fc_m + 16'd1;
    else sf_m = 1'b1;
    cyc(2);
  endtask

  task automatic full_frame(output logic [DW-1:0] cap, output logic [DW-1:0] exp);
    frame_start(1'b0, '0, exp);
    shift_bits(DW, cap);
    cyc(1);
    frame_end(1'b0, 1'b1);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    cyc(3);
    checks++;
    if ({sdata, smp_full, smp_level, underrun, short_frame, frame_cnt} !== '0) begin
      failures++;
      $display("FAIL reset_state got sdata=%b full=%b level=%0d uf=%b sf=%b fc=%0d exp all zero",
               sdata, smp_full, smp_level, underrun, short_frame, frame_cnt);
    end
    rst = 1'b0;
    cyc(5);
  endtask

  task automatic test_basic();
    logic [DW-1:0] cap, exp;
    wr(16'hA5C3);
    checks++;
    if (smp_level !== 3'd1) begin failures++; $display("FAIL basic_level1 got=%0d exp=1", smp_level); end
    cs_n = 1'b0;
    cyc(2);
    checks++;
    if (sdata !== 1'b0) begin failures++; $display("FAIL latency_early got=%b exp=0", sdata); end
    cyc(1);
    checks++;
    if (sdata !== 1'b1) begin failures++; $display("FAIL latency_edge3 got=%b exp=1", sdata); end
    exp = model_load();
    cyc(1);
    shift_bits(DW, cap);
    cyc(1);
    frame_end(1'b0, 1'b1);
    checks++;
    if (cap !== 16'hA5C3 || cap !== exp) begin failures++; $display("FAIL basic_capture got=%h exp=%h", cap, exp); end
    checks++;
    if (frame_cnt !== 16'd1 || underrun !== 1'b0 || smp_level !== 3'd0) begin
      failures++;
      $display("FAIL basic_status got fc=%0d uf=%b lvl=%0d exp fc=1 uf=0 lvl=0", frame_cnt, underrun, smp_level);
    end
  endtask

  task automatic test_ramp();
    logic [DW-1:0] cap, exp;
    clr_pulse();
    ramp_en = 1'b1;
    for (int k = 0; k < 3; k++) begin
      full_frame(cap, exp);
      checks++;
      if (cap !== DW'(k) || cap !== exp) begin failures++; $display("FAIL ramp_value%0d got=%h exp=%h", k, cap, DW'(k)); end
    end
    checks++;
    if (underrun !== 1'b1 || frame_cnt !== 16'd3) begin
      failures++;
      $display("FAIL ramp_status got uf=%b fc=%0d exp uf=1 fc=3", underrun, frame_cnt);
    end
    ramp_en = 1'b0;
    full_frame(cap, exp);
    checks++;
    if (cap !== '0 || cap !== exp) begin failures++; $display("FAIL ramp_off got=%h exp=0000", cap); end
  endtask

  task automatic test_fifo_full();
    logic [DW-1:0] cap, exp, d;
    for (int i = 0; i < 5; i++) wr(DW'($urandom));
    checks++;
    if (smp_level !== 3'd4 || smp_full !== 1'b1) begin
      failures++;
      $display("FAIL fifo_full got lvl=%0d full=%b exp lvl=4 full=1", smp_level, smp_full);
    end
    d = DW'($urandom);
    frame_start(1'b1, d, exp);
    checks++;
    if (smp_level !== 3'd4 || smp_full !== 1'b1) begin
      failures++;
      $display("FAIL full_pop_write got lvl=%0d full=%b exp lvl=4 full=1", smp_level, smp_full);
    end
    shift_bits(DW, cap);
    cyc(1);
    frame_end(1'b0, 1'b1);
    checks++;
    if (cap !== exp) begin failures++; $display("FAIL full_first got=%h exp=%h", cap, exp); end
    for (int i = 0; i < 4; i++) begin
      full_frame(cap, exp);
      checks++;
      if (cap !== exp) begin failures++; $display("FAIL drain%0d got=%h exp=%h", i, cap, exp); end
    end
    checks++;
    if (smp_level !== 3'd0 || smp_full !== 1'b0 || frame_cnt !== fc_m) begin
      failures++;
      $display("FAIL drain_status got lvl=%0d full=%b fc=%0d exp lvl=0 full=0 fc=%0d", smp_level, smp_full, frame_cnt, fc_m);
    end
  endtask

  task automatic test_short();
    logic [DW-1:0] a, b, cap, exp;
    logic [15:0]   fc_before;
    a = DW'($urandom);
    b = DW'($urandom);
    wr(a);
    wr(b);
    fc_before = fc_m;
    frame_start(1'b0, '0, exp);
    shift_bits(9, cap);
    cyc(1);
    frame_end(1'b0, 1'b0);
    checks++;
    if (cap[8:0] !== a[15:7]) begin failures++; $display("FAIL short_bits got=%h exp=%h", cap[8:0], a[15:7]); end
    checks++;
    if (short_frame !== 1'b1 || frame_cnt !== fc_before) begin
      failures++;
      $display("FAIL short_status got sf=%b fc=%0d exp sf=1 fc=%0d", short_frame, frame_cnt, fc_before);
    end
    full_frame(cap, exp);
    checks++;
    if (cap !== b || cap !== exp) begin failures++; $display("FAIL short_next got=%h exp=%h", cap, b); end
  endtask

  task automatic test_ignore();
    logic [DW-1:0] d, cap, exp, junk;
    shift_bits(3, junk);
    checks++;
    if (sdata !== 1'b0 || junk[2:0] !== 3'b000) begin failures++; $display("FAIL idle_sclk got=%b exp=0", sdata); end
    d = DW'($urandom);
    wr(d);
    frame_start(1'b0, '0, exp);
    shift_bits(DW, cap);
    shift_bits(2, junk);
    checks++;
    if (junk[1:0] !== 2'b00 || sdata !== 1'b0) begin failures++; $display("FAIL done_extra got=%b exp=00", junk[1:0]); end
    frame_end(1'b0, 1'b1);
    checks++;
    if (cap !== d || frame_cnt !== fc_m) begin
      failures++;
      $display("FAIL ignore_capture got=%h fc=%0d exp=%h fc=%0d", cap, frame_cnt, d, fc_m);
    end
  endtask

  task automatic test_mid_reset();
    logic [DW-1:0] d, cap, exp, junk;
    wr(DW'($urandom));
    frame_start(1'b0, '0, exp);
    shift_bits(7, cap);
    rst = 1'b1;
    cyc(2);
    checks++;
    if (sdata !== 1'b0 || smp_level !== 3'd0) begin failures++; $display("FAIL midrst_hold got sdata=%b lvl=%0d exp 0 0", sdata, smp_level); end
    rst = 1'b0;
    mq.delete();
    ramp_m = '0;
    uf_m = 1'b0;
    sf_m = 1'b0;
    fc_m = '0;
    shift_bits(DW, junk);
    checks++;
    if (junk !== '0 || sdata !== 1'b0) begin failures++; $display("FAIL midrst_sclk got=%h exp=0000", junk); end
    cs_n = 1'b1;
    cyc(6);
    checks++;
    if (frame_cnt !== 16'd0 || short_frame !== 1'b0) begin
      failures++;
      $display("FAIL midrst_count got fc=%0d sf=%b exp fc=0 sf=0", frame_cnt, short_frame);
    end
    d = DW'($urandom);
    wr(d);
    full_frame(cap, exp);
    checks++;
    if (cap !== d || frame_cnt !== 16'd1) begin failures++; $display("FAIL midrst_next got=%h fc=%0d exp=%h fc=1", cap, frame_cnt, d); end
  endtask

  task automatic test_clr_collide();
    logic [DW-1:0] cap, exp;
    ramp_en = 1'b0;
    full_frame(cap, exp);
    wr(DW'($urandom));
    frame_start(1'b0, '0, exp);
    shift_bits(DW, cap);
    cyc(1);
    frame_end(1'b1, 1'b1);
    checks++;
    if (frame_cnt !== 16'd1 || underrun !== 1'b0 || short_frame !== 1'b0 || cap !== exp) begin
      failures++;
      $display("FAIL clr_done got fc=%0d uf=%b sf=%b exp fc=1 uf=0 sf=0", frame_cnt, underrun, short_frame);
    end
    cs_n = 1'b0;
    cyc(2);
    stat_clr = 1'b1;
    cyc(1);
    stat_clr = 1'b0;
    uf_m = 1'b0;
    sf_m = 1'b0;
    fc_m = '0;
    exp = model_load();
    cyc(1);
    shift_bits(DW, cap);
    cyc(1);
    frame_end(1'b0, 1'b1);
    checks++;
    if (underrun !== 1'b1 || frame_cnt !== 16'd1 || cap !== '0) begin
      failures++;
      $display("FAIL clr_vs_underrun got uf=%b fc=%0d cap=%h exp uf=1 fc=1 cap=0000", underrun, frame_cnt, cap);
    end
  endtask

  task automatic test_random();
    logic [DW-1:0] cap, exp;
    int nw;
    for (int it = 0; it < 8; it++) begin
      ramp_en = 1'($urandom_range(0, 1));
      nw = $urandom_range(0, 3);
      for (int i = 0; i < nw; i++) wr(DW'($urandom));
      full_frame(cap, exp);
      checks++;
      if (cap !== exp) begin failures++; $display("FAIL rand_capture%0d got=%h exp=%h", it, cap, exp); end
      checks++;
      if (frame_cnt !== fc_m || underrun !== uf_m || short_frame !== sf_m ||
          smp_level !== LW'(mq.size()) || smp_full !== (mq.size() == DEPTH)) begin
        failures++;
        $display("FAIL rand_status%0d got fc=%0d uf=%b sf=%b lvl=%0d exp fc=%0d uf=%b sf=%b lvl=%0d",
                 it, frame_cnt, underrun, short_frame, smp_level, fc_m, uf_m, sf_m, mq.size());
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_ramp();
    test_fifo_full();
    test_short();
    test_ignore();
    test_mid_reset();
    test_clr_collide();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
